// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control path:
// FSM states, opcode/funct encodings and ALU operation selects.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_REX,
      S_RWB,
      S_BEQ,
      S_ADDIEX,
      S_ADDIWB,
      S_JMP,
      S_HALT
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

endpackage

// File: rtl/mc_funct_decode.sv
// R-type funct field to ALU operation select, with a legality flag.
// Unknown functs fall back to AND so the ALU input stays defined.
module mc_funct_decode
   import mc_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_op,
   output logic       legal
);

   always_comb begin
      alu_op = ALU_AND;
      legal  = 1'b1;
      case (funct)
         F_ADD:   alu_op = ALU_ADD;
         F_SUB:   alu_op = ALU_SUB;
         F_AND:   alu_op = ALU_AND;
         F_OR:    alu_op = ALU_OR;
         default: legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath selects and the ALU op, counts retired instructions.
module mc_control_unit
   import mc_pkg::*;
#(
   parameter int ALU_OP_W = 4,
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic                alu_zero,
   input  logic                mem_ready,
   output logic                pc_en,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          pc_src,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                illegal,
   output logic [CNT_W-1:0]    instret
);

   state_t     state;
   state_t     state_n;
   logic [3:0] op;
   logic [3:0] f_op;
   logic       f_legal;
   logic       retire;
   logic       set_ill;

   mc_funct_decode u_fdec (
      .funct  (funct),
      .alu_op (f_op),
      .legal  (f_legal)
   );

   assign alu_op = ALU_OP_W'(op);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_FETCH;
         illegal <= 1'b0;
         instret <= '0;
      end else begin
         state <= state_n;
         if (set_ill)
            illegal <= 1'b1;
         if (retire)
            instret <= instret + CNT_W'(1);
      end
   end

   always_comb begin
      state_n    = state;
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      op         = ALU_AND;
      retire     = 1'b0;
      set_ill    = 1'b0;
      case (state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            op        = ALU_ADD;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_en    = 1'b1;
               state_n  = S_DECODE;
            end
         end
         S_DECODE: begin
            // speculative branch target: PC + (imm << 2)
            alu_src_b = 2'b11;
            op        = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW: state_n = S_MEMADR;
               OP_RTYPE:     state_n = S_REX;
               OP_BEQ:       state_n = S_BEQ;
               OP_ADDI:      state_n = S_ADDIEX;
               OP_J:         state_n = S_JMP;
               default: begin
                  state_n = S_HALT;
                  set_ill = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            op        = ALU_ADD;
            state_n   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            if (mem_ready)
               state_n = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            state_n    = S_FETCH;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_n = S_FETCH;
            end
         end
         S_REX: begin
            alu_src_a = 1'b1;
            op        = f_op;
            if (f_legal) begin
               state_n = S_RWB;
            end else begin
               state_n = S_HALT;
               set_ill = 1'b1;
            end
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retire    = 1'b1;
            state_n   = S_FETCH;
         end
         S_BEQ: begin
            // alu_zero is high on a non-zero difference, so taken = low
            alu_src_a = 1'b1;
            op        = ALU_SUB;
            pc_src    = 2'b01;
            pc_en     = ~alu_zero;
            retire    = 1'b1;
            state_n   = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            op        = ALU_ADD;
            state_n   = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_n   = S_FETCH;
         end
         S_JMP: begin
            pc_src  = 2'b10;
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_n = S_FETCH;
         end
         S_HALT:  state_n = S_HALT;
         default: state_n = S_FETCH;
      endcase
      if (reset) begin
         pc_en      = 1'b0;
         iord       = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         reg_write  = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         pc_src     = 2'b00;
         op         = ALU_AND;
         retire     = 1'b0;
         set_ill    = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: vector table, hand-written
// corner sequences and random instruction streams vs. a per-instruction model.
module tb_mc_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        alu_zero;
   logic        mem_ready;
   logic        pc_en, iord, mem_read, mem_write, ir_write;
   logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, pc_src;
   logic [3:0]  alu_op;
   logic        illegal;
   logic [31:0] instret;

   mc_control_unit #(.ALU_OP_W(4), .CNT_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .alu_zero   (alu_zero),
      .mem_ready  (mem_ready),
      .pc_en      (pc_en),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .pc_src     (pc_src),
      .alu_op     (alu_op),
      .illegal    (illegal),
      .instret    (instret)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   int c_mr, c_mw, c_rw, c_ir, c_pc, c_iord;
   logic        s_dst, s_m2r, s_a, s_pce;
   logic [1:0]  s_b, s_pcs;
   logic [3:0]  s_op;
   logic [16:0] s_all;
   logic        e_a, e_pce;
   logic [1:0]  e_b, e_pcs;
   logic [3:0]  e_op;

   // FETCH cycle with mem_ready=1, in s_all bit order
   localparam logic [16:0] FETCH_ALL = 17'b1_0_1_0_1_0_0_0_0_01_00_0010;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       az;
      logic       a;
      logic [1:0] b;
      logic [3:0] aop;
      logic [1:0] pcs;
      logic       pce;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic mr, input logic az);
      mem_ready = mr;
      alu_zero  = az;
      @(negedge clk);
      chk("excl_read_write", 32'(mem_read & mem_write), 0);
      chk("excl_regw_memw", 32'(reg_write & mem_write), 0);
      c_mr   += int'(mem_read);
      c_mw   += int'(mem_write);
      c_rw   += int'(reg_write);
      c_ir   += int'(ir_write);
      c_pc   += int'(pc_en);
      c_iord += int'(iord);
      if (reg_write) begin
         s_dst = reg_dst;
         s_m2r = mem_to_reg;
      end
      s_a   = alu_src_a;
      s_b   = alu_src_b;
      s_op  = alu_op;
      s_pcs = pc_src;
      s_pce = pc_en;
      s_all = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_op};
      @(posedge clk);
      #1;
   endtask

   // One legal instruction: fs fetch stalls, ms memory stalls.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int fs, input int ms, input logic az);
      bit          is_lw, is_sw, is_mem, is_r, wb;
      int          tot;
      logic [31:0] i0;
      logic        mr;
      is_lw  = (op == 6'h23);
      is_sw  = (op == 6'h2B);
      is_mem = is_lw || is_sw;
      is_r   = (op == 6'h00);
      wb     = is_lw || is_r || (op == 6'h08);
      tot    = is_lw ? 5 : ((op == 6'h04 || op == 6'h02) ? 3 : 4);
      tot    = tot + fs + (is_mem ? ms : 0);
      opcode = op;
      funct  = fn;
      c_mr = 0; c_mw = 0; c_rw = 0; c_ir = 0; c_pc = 0; c_iord = 0;
      s_dst = 1'bx;
      s_m2r = 1'bx;
      i0 = instret;
      for (int k = 0; k < tot; k++) begin
         if (k < fs)
            mr = 1'b0;
         else if (k == fs)
            mr = 1'b1;
         else if (is_mem && k >= fs + 3)
            mr = (k >= fs + 3 + ms);
         else
            mr = 1'($urandom);
         cyc(mr, az);
         if (k == fs + 1) begin
            chk("decode_src_b", 32'(s_b), 3);
            chk("decode_alu_op", 32'(s_op), 2);
         end
         if (k == fs + 2) begin
            e_a = s_a; e_b = s_b; e_op = s_op; e_pcs = s_pcs; e_pce = s_pce;
         end
      end
      chk("mem_read_cycles", c_mr, fs + 1 + (is_lw ? ms + 1 : 0));
      chk("mem_write_cycles", c_mw, is_sw ? ms + 1 : 0);
      chk("iord_cycles", c_iord, is_mem ? ms + 1 : 0);
      chk("reg_write_cycles", c_rw, wb ? 1 : 0);
      chk("ir_write_cycles", c_ir, 1);
      chk("pc_en_cycles", c_pc,
          1 + ((op == 6'h02) ? 1 : 0) + ((op == 6'h04 && !az) ? 1 : 0));
      chk("instret_step", instret, i0 + 1);
      if (wb) begin
         chk("wb_reg_dst", 32'(s_dst), is_r ? 1 : 0);
         chk("wb_mem_to_reg", 32'(s_m2r), is_lw ? 1 : 0);
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         cyc(1'($urandom), 1'($urandom));
         chk("reset_outputs_zero", 32'(s_all), 0);
      end
      reset = 1'b0;
      chk("reset_instret", instret, 0);
      chk("reset_illegal", 32'(illegal), 0);
   endtask

   task automatic halt_check(input int n, input logic [31:0] ret);
      for (int i = 0; i < n; i++) begin
         cyc(1'($urandom), 1'($urandom));
         chk("halt_enables", 32'({c_pc, c_ir, c_rw, c_mr, c_mw}), 0);
      end
      chk("halt_instret", instret, ret);
      chk("halt_illegal", 32'(illegal), 1);
   endtask

   vec_t vt[10];

   initial begin
      logic [5:0]  ops[6];
      logic [5:0]  fns[4];
      logic [31:0] exp_ret;
      logic [31:0] r0;
      ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25};
      vt[0] = '{6'h23, 6'h00, 1'b0, 1'b1, 2'b10, 4'b0010, 2'b00, 1'b0};
      vt[1] = '{6'h2B, 6'h00, 1'b0, 1'b1, 2'b10, 4'b0010, 2'b00, 1'b0};
      vt[2] = '{6'h00, 6'h20, 1'b0, 1'b1, 2'b00, 4'b0010, 2'b00, 1'b0};
      vt[3] = '{6'h00, 6'h22, 1'b0, 1'b1, 2'b00, 4'b0110, 2'b00, 1'b0};
      vt[4] = '{6'h00, 6'h24, 1'b0, 1'b1, 2'b00, 4'b0000, 2'b00, 1'b0};
      vt[5] = '{6'h00, 6'h25, 1'b0, 1'b1, 2'b00, 4'b0001, 2'b00, 1'b0};
      vt[6] = '{6'h04, 6'h00, 1'b0, 1'b1, 2'b00, 4'b0110, 2'b01, 1'b1};
      vt[7] = '{6'h04, 6'h00, 1'b1, 1'b1, 2'b00, 4'b0110, 2'b01, 1'b0};
      vt[8] = '{6'h08, 6'h00, 1'b0, 1'b1, 2'b10, 4'b0010, 2'b00, 1'b0};
      vt[9] = '{6'h02, 6'h00, 1'b0, 1'b0, 2'b00, 4'b0000, 2'b10, 1'b1};

      reset = 1'b1; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk);
      #1;

      // reset held 3 cycles, then a jump
      do_reset(3);
      opcode = 6'h02;
      cyc(1'b1, 1'b0);
      chk("first_fetch", 32'(s_all), 32'(FETCH_ALL));
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      chk("first_retire", instret, 1);

      // table: execute-cycle decodes with mem_ready high
      for (int i = 0; i < 10; i++) begin
         run_instr(vt[i].op, vt[i].fn, 0, 0, vt[i].az);
         chk("vec_src_a", 32'(e_a), 32'(vt[i].a));
         chk("vec_src_b", 32'(e_b), 32'(vt[i].b));
         chk("vec_alu_op", 32'(e_op), 32'(vt[i].aop));
         chk("vec_pc_src", 32'(e_pcs), 32'(vt[i].pcs));
         chk("vec_pc_en", 32'(e_pce), 32'(vt[i].pce));
      end

      // lw with two memory stalls: 7 cycles, 3 cycles of iord/mem_read
      run_instr(6'h23, 6'h00, 0, 2, 1'b0);

      // random instruction stream
      exp_ret = instret;
      for (int i = 0; i < 150; i++) begin
         run_instr(ops[$urandom_range(0, 5)], fns[$urandom_range(0, 3)],
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
         exp_ret = exp_ret + 1;
      end
      chk("random_instret_total", instret, exp_ret);

      // reset during RWB abandons the write
      opcode = 6'h00; funct = 6'h20;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      reset = 1'b1;
      cyc(1'b1, 1'b0);
      chk("rwb_reset_no_write", 32'(s_all), 0);
      reset = 1'b0;
      chk("rwb_reset_instret", instret, 0);
      cyc(1'b1, 1'b0);
      chk("rwb_reset_fetch", 32'(s_all), 32'(FETCH_ALL));
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      chk("rwb_reset_retire", instret, 1);

      // unsupported opcode halts after decode
      r0 = instret;
      opcode = 6'h3F;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      c_mr = 0; c_mw = 0; c_rw = 0; c_ir = 0; c_pc = 0; c_iord = 0;
      halt_check(22, r0);
      do_reset(1);

      // unsupported funct halts after REX with alu_op AND
      opcode = 6'h00; funct = 6'h3F;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      chk("bad_funct_alu_op", 32'(s_op), 0);
      c_mr = 0; c_mw = 0; c_rw = 0; c_ir = 0; c_pc = 0; c_iord = 0;
      halt_check(6, 0);
      do_reset(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
